// File: rtl/noc_input_port.sv
// noc_input_port -- router input-port unit (one per mesh direction).
//
// Buffers wormhole flits in a small FIFO and computes the XY route from the
// head flit. It requests one output port, holds the route for the whole
// packet, and releases it when the tail flit leaves.
//
// Flit type in [FLIT_W-1:FLIT_W-2]: 00 single, 01 head, 10 body, 11 tail.
// Head/single flits carry dest_x in [2*COORD_W-1:COORD_W] and dest_y in [COORD_W-1:0].
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid/in_data      upstream flit; taken when in_valid & in_ready
//   in_ready              FIFO not full (0 while rst is high)
//   out_req[4:0]          registered one-hot request: [0]N [1]S [2]E [3]W [4]L
//   out_grant             1-cycle grant for out_req (ignored outside ROUTE)
//   out_valid/out_data    FIFO head presented to the crossbar (data 0 when empty)
//   out_ready             crossbar accepts; pop on out_valid & out_ready
//   out_tail              out_data is a tail or single flit
//   flit_cnt[15:0]        forwarded flits, saturating   (NOC_INPORT_STATS_EN only)
//   drop_cnt[7:0]         dropped flits, saturating     (NOC_INPORT_STATS_EN only)
//
// Optional build macro: NOC_INPORT_STATS_EN adds the two statistics counters.
module noc_input_port #(
  parameter int XCOORD  = 2,
  parameter int YCOORD  = 2,
  parameter int COORD_W = 4,
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_ready,
  output logic [4:0]        out_req,
  input  logic              out_grant,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_tail
`ifdef NOC_INPORT_STATS_EN
  ,
  output logic [15:0]       flit_cnt,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] T_SINGLE = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUTE = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_S = 5'b00010;
  localparam logic [4:0] R_E = 5'b00100;
  localparam logic [4:0] R_W = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  localparam logic [COORD_W-1:0] X_HERE = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] Y_HERE = COORD_W'(YCOORD);

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               full, empty, push, pop, drop, fwd;
  logic [1:0]         state;
  logic [FLIT_W-1:0]  head;
  logic [1:0]         head_type;
  logic               head_is_start, head_is_end;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [4:0]         route;

  // ---------------- FIFO ----------------
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Gated by rst so every output reads 0 while reset is held.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = drop || fwd;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- head decode / XY route ----------------
  assign head          = empty ? '0 : mem[rd_ptr];
  assign head_type     = head[FLIT_W-1 -: 2];
  assign head_is_start = !head_type[1];                      // single or head
  assign head_is_end   = (head_type == T_SINGLE) || (head_type == T_TAIL);
  assign dest_x        = head[2*COORD_W-1:COORD_W];
  assign dest_y        = head[COORD_W-1:0];

  always_comb begin
    route = R_L;
    if      (dest_x > X_HERE) route = R_E;
    else if (dest_x < X_HERE) route = R_W;
    else if (dest_y > Y_HERE) route = R_N;
    else if (dest_y < Y_HERE) route = R_S;
  end

  // ---------------- packet FSM ----------------
  // A body/tail flit at the head while IDLE has no route: discard it.
  assign drop      = (state == IDLE) && !empty && !head_is_start;
  assign out_valid = (state == SEND) && !empty;
  assign fwd       = out_valid && out_ready;
  assign out_data  = head;
  // Qualified by out_valid: an empty FIFO reads as 0, which decodes as "single".
  assign out_tail  = out_valid && head_is_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_req <= '0;
    end else begin
      case (state)
        IDLE: if (!empty && head_is_start) begin
          state   <= ROUTE;
          out_req <= route;
        end
        ROUTE: if (out_grant) begin
          state   <= SEND;
          out_req <= '0;
        end
        // Empty FIFO mid-packet simply waits here.
        SEND: if (fwd && head_is_end) state <= IDLE;
        default: begin
          state   <= IDLE;
          out_req <= '0;
        end
      endcase
    end
  end

`ifdef NOC_INPORT_STATS_EN
  // ---------------- statistics ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd  && (flit_cnt != '1)) flit_cnt <= flit_cnt + 16'd1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
